// File: rtl/proc_trace_checker.sv
// proc_trace_checker: run controller and write-back self-checker for the skeleton
// processor. It holds the processor in reset for a fixed number of cycles, then
// compares each observed regfile write against a preloaded expected trace. It reports
// pass/fail, the mismatch count, the first failing trace index and the elapsed RUN
// cycles.
//
// Load interface: load_valid has no ready. An entry is taken on the rising edge when
// load_valid=1 and all of the following hold:
//   - the checker is IDLE or DONE;
//   - start and clear are both low;
//   - the trace is not full.
// In every other case the entry is silently dropped.
module proc_trace_checker #(
    parameter int DATA_W       = 32,
    parameter int REG_W        = 5,
    parameter int DEPTH        = 64,
    parameter int RESET_CYCLES = 2,
    parameter int TIMEOUT      = 4096,
    parameter int CNT_W        = 16,
    localparam int IDX_W       = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [REG_W-1:0]  load_reg,
    input  logic [DATA_W-1:0] load_data,
    input  logic              clear,
    input  logic              start,
    input  logic              wb_en,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              proc_reset,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timed_out,
    output logic [CNT_W-1:0]  error_count,
    output logic [IDX_W:0]    fail_index,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [1:0]        state_dbg
);

    localparam int ENT_W  = REG_W + DATA_W;
    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_d;

    logic [ENT_W-1:0]  trace_mem [DEPTH];
    logic [IDX_W:0]    count;
    logic [IDX_W:0]    ptr;
    logic [HOLD_W-1:0] hold_cnt;

    logic             idle_like;
    logic             do_start;
    logic             do_clear;
    logic             do_load;
    logic             wb_take;
    logic             wb_miss;
    logic             last_write;
    logic             hold_last;
    logic             run_timeout;
    logic [ENT_W-1:0] exp_entry;

    // Decode command priority (start > clear > load) and the per-cycle compare events.
    always_comb begin
        idle_like   = (state == S_IDLE) || (state == S_DONE);
        do_start    = idle_like && start;
        do_clear    = idle_like && !start && clear;
        do_load     = idle_like && !start && !clear && load_valid &&
                      (count != (IDX_W+1)'(DEPTH));
        exp_entry   = trace_mem[ptr[IDX_W-1:0]];
        wb_take     = (state == S_RUN) && wb_en && (wb_reg != '0);
        wb_miss     = wb_take && ({wb_reg, wb_data} != exp_entry);
        last_write  = wb_take && (ptr == count - (IDX_W+1)'(1));
        hold_last   = (state == S_HOLD) && (hold_cnt == HOLD_W'(RESET_CYCLES - 1));
        run_timeout = (state == S_RUN) && (cycle_count == CNT_W'(TIMEOUT - 1));
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // FSM next state and state-decoded outputs.
    always_comb begin
        state_d    = state;
        proc_reset = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        pass       = 1'b0;
        case (state)
            S_IDLE: begin
                if (do_start) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                busy = 1'b1;
                if (hold_last) begin
                    state_d = (count == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy       = 1'b1;
                proc_reset = 1'b0;
                if (last_write || run_timeout) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                pass = (error_count == '0) && !timed_out;
                if (do_start) begin
                    state_d = S_HOLD;
                end else if (do_clear) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign state_dbg = state;

    // Expected-trace storage; contents survive reset, only the count is cleared.
    always_ff @(posedge clock) begin
        if (do_load) begin
            trace_mem[count[IDX_W-1:0]] <= {load_reg, load_data};
        end
    end

    // Trace fill level: cleared by clear, advanced by each accepted load.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (do_clear) begin
            count <= '0;
        end else if (do_load) begin
            count <= count + (IDX_W+1)'(1);
        end
    end

    // Processor reset hold timer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
        end else if (do_start) begin
            hold_cnt <= '0;
        end else if (state == S_HOLD) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    // Run bookkeeping: trace pointer, cycle and error counters, first-fail index, timeout.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr         <= '0;
            cycle_count <= '0;
            error_count <= '0;
            fail_index  <= '1;
            timed_out   <= 1'b0;
        end else if (do_start) begin
            ptr         <= '0;
            cycle_count <= '0;
            error_count <= '0;
            fail_index  <= '1;
            timed_out   <= 1'b0;
        end else begin
            if (state == S_RUN && cycle_count != '1) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
            if (wb_take) begin
                ptr <= ptr + (IDX_W+1)'(1);
            end
            if (wb_miss && error_count != '1) begin
                error_count <= error_count + CNT_W'(1);
            end
            if (wb_miss && fail_index == '1) begin
                fail_index <= ptr;
            end
            // A final matching-count write on the timeout edge wins over the timeout.
            if (run_timeout && !last_write) begin
                timed_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_proc_trace_checker.sv
// tb_proc_trace_checker: directed scenarios with a reference model of the trace
// checker and a queue of expected {fail_index, error_count} results per compared write.
module tb_proc_trace_checker;

    localparam int DATA_W       = 32;
    localparam int REG_W        = 5;
    localparam int DEPTH        = 64;
    localparam int RESET_CYCLES = 2;
    localparam int TIMEOUT      = 16;
    localparam int CNT_W        = 16;
    localparam int IDX_W        = 6;
    localparam int SB_W         = IDX_W + 1 + CNT_W;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              load_valid = 1'b0;
    logic [REG_W-1:0]  load_reg = '0;
    logic [DATA_W-1:0] load_data = '0;
    logic              clear = 1'b0;
    logic              start = 1'b0;
    logic              wb_en = 1'b0;
    logic [REG_W-1:0]  wb_reg = '0;
    logic [DATA_W-1:0] wb_data = '0;
    logic              proc_reset;
    logic              busy;
    logic              done;
    logic              pass;
    logic              timed_out;
    logic [CNT_W-1:0]  error_count;
    logic [IDX_W:0]    fail_index;
    logic [CNT_W-1:0]  cycle_count;
    logic [1:0]        state_dbg;

    proc_trace_checker #(
        .DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH),
        .RESET_CYCLES(RESET_CYCLES), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset),
        .load_valid(load_valid), .load_reg(load_reg), .load_data(load_data),
        .clear(clear), .start(start),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .proc_reset(proc_reset), .busy(busy), .done(done), .pass(pass),
        .timed_out(timed_out), .error_count(error_count), .fail_index(fail_index),
        .cycle_count(cycle_count), .state_dbg(state_dbg)
    );

    // Clock generation.
    always #5 clock = ~clock;

    // Reference model and scoreboard.
    logic [REG_W+DATA_W-1:0] m_trace [DEPTH];
    int                      m_count = 0;
    int                      m_ptr = 0;
    int                      m_cycles = 0;
    logic [CNT_W-1:0]        m_err = '0;
    logic [IDX_W:0]          m_fail = '1;
    logic                    m_last = 1'b0;
    logic                    m_timed = 1'b0;
    logic [SB_W-1:0]         exp_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // All tasks are entered and left at a falling clock edge.
    task automatic load_entry(input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d);
        load_valid = 1'b1;
        load_reg   = r;
        load_data  = d;
        @(negedge clock);
        load_valid = 1'b0;
        if (m_count < DEPTH) begin
            m_trace[m_count] = {r, d};
            m_count++;
        end
    endtask

    task automatic clear_trace();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        m_count = 0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || proc_reset !== 1'b1) begin
            $display("FAIL clear_idle: done=%b busy=%b proc_reset=%b, required 0 0 1",
                     done, busy, proc_reset);
        end else n_pass++;
    endtask

    // Pulse start, count observed HOLD cycles while driving writes that must be ignored.
    task automatic start_run(input logic with_load);
        int hold_seen;
        start      = 1'b1;
        load_valid = with_load;
        load_reg   = 5'd4;
        load_data  = 32'h1234;
        m_ptr = 0; m_cycles = 0; m_err = '0; m_fail = '1; m_last = 1'b0; m_timed = 1'b0;
        exp_q.delete();
        @(negedge clock);
        start      = 1'b0;
        load_valid = 1'b0;
        hold_seen  = 0;
        for (int i = 0; i < 20; i++) begin
            if (!(busy && proc_reset)) break;
            hold_seen++;
            wb_en   = 1'b1;
            wb_reg  = 5'd3;
            wb_data = 32'hBAD0_0000 + 32'(i);
            @(negedge clock);
        end
        wb_en = 1'b0;
        n_checks++;
        if (hold_seen !== RESET_CYCLES) begin
            $display("FAIL hold_cycles: got %0d, required %0d", hold_seen, RESET_CYCLES);
        end else n_pass++;
        n_checks++;
        if (m_count == 0) begin
            if (done !== 1'b1 || pass !== 1'b1) begin
                $display("FAIL empty_done: done=%b pass=%b, required 1 1", done, pass);
            end else n_pass++;
        end else begin
            if (proc_reset !== 1'b0 || busy !== 1'b1) begin
                $display("FAIL run_entry: proc_reset=%b busy=%b, required 0 1",
                         proc_reset, busy);
            end else n_pass++;
        end
    endtask

    // One RUN cycle of write-back stimulus with model update and scoreboard check.
    task automatic drive_wb(input logic en, input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d);
        logic            considered;
        logic            mism;
        logic [SB_W-1:0] exp;
        wb_en   = en;
        wb_reg  = r;
        wb_data = d;
        considered = en && (r != '0);
        m_cycles++;
        if (considered) begin
            mism = ({r, d} !== m_trace[m_ptr]);
            if (mism && m_err != '1) m_err = m_err + 1'b1;
            if (mism && m_fail == '1) m_fail = (IDX_W+1)'(m_ptr);
            if (m_ptr == m_count - 1) m_last = 1'b1;
            m_ptr++;
            exp_q.push_back({m_fail, m_err});
        end
        m_timed = (m_cycles == TIMEOUT) && !m_last;
        @(negedge clock);
        wb_en = 1'b0;
        if (considered) begin
            exp = exp_q.pop_front();
            n_checks++;
            if ({fail_index, error_count} !== exp) begin
                $display("FAIL wb_result: fail_index=%0d error_count=%0d, required %0d %0d",
                         fail_index, error_count, exp[SB_W-1:CNT_W], exp[CNT_W-1:0]);
            end else n_pass++;
        end
        n_checks++;
        if (cycle_count !== CNT_W'(m_cycles) || done !== (m_last || m_timed)) begin
            $display("FAIL run_cycle: cycle_count=%0d done=%b, required %0d %b",
                     cycle_count, done, m_cycles, (m_last || m_timed));
        end else n_pass++;
    endtask

    task automatic idle_until_done();
        for (int i = 0; i < 40; i++) begin
            if (m_last || m_timed) break;
            drive_wb(1'b0, '0, '0);
        end
    endtask

    task automatic check_done_outputs(input string name);
        logic exp_pass;
        exp_pass = (m_err == '0) && !m_timed;
        n_checks++;
        if (done !== 1'b1 || pass !== exp_pass || timed_out !== m_timed ||
            error_count !== m_err || fail_index !== m_fail || proc_reset !== 1'b1 ||
            busy !== 1'b0) begin
            $display("FAIL %s: done=%b pass=%b timed_out=%b err=%0d fail_idx=%0d prst=%b busy=%b, required 1 %b %b %0d %0d 1 0",
                     name, done, pass, timed_out, error_count, fail_index, proc_reset, busy,
                     exp_pass, m_timed, m_err, m_fail);
        end else n_pass++;
    endtask

    task automatic check_reset_values(input string name);
        n_checks++;
        if (proc_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
            timed_out !== 1'b0 || error_count !== '0 || fail_index !== 7'h7f ||
            cycle_count !== '0) begin
            $display("FAIL %s: prst=%b busy=%b done=%b pass=%b to=%b err=%0d fidx=%0h cyc=%0d, required 1 0 0 0 0 0 7f 0",
                     name, proc_reset, busy, done, pass, timed_out, error_count, fail_index,
                     cycle_count);
        end else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_reset_values("reset_values");
        reset = 1'b1;
        @(negedge clock);
        check_reset_values("after_reset_release");
    endtask

    task automatic test_match();
        load_entry(5'd1, 32'd5);
        load_entry(5'd2, 32'd7);
        start_run(1'b0);
        drive_wb(1'b1, 5'd1, 32'd5);
        drive_wb(1'b1, 5'd0, 32'd9);
        drive_wb(1'b1, 5'd2, 32'd7);
        check_done_outputs("match_done");
    endtask

    task automatic test_mismatch();
        start_run(1'b0);
        drive_wb(1'b1, 5'd1, 32'd5);
        drive_wb(1'b1, 5'd2, 32'd8);
        check_done_outputs("mismatch_data");
        start_run(1'b0);
        drive_wb(1'b1, 5'd3, 32'd5);
        drive_wb(1'b1, 5'd2, 32'd8);
        check_done_outputs("mismatch_first_index");
    endtask

    task automatic test_timeout();
        clear_trace();
        load_entry(5'd1, 32'd5);
        load_entry(5'd2, 32'd7);
        load_entry(5'd3, 32'd9);
        start_run(1'b0);
        drive_wb(1'b1, 5'd1, 32'd5);
        idle_until_done();
        check_done_outputs("timeout_done");
        n_checks++;
        if (cycle_count !== CNT_W'(TIMEOUT)) begin
            $display("FAIL timeout_cycles: got %0d, required %0d", cycle_count, TIMEOUT);
        end else n_pass++;
    endtask

    task automatic test_full_and_empty();
        clear_trace();
        for (int i = 0; i < DEPTH; i++) begin
            load_entry(5'((i % 31) + 1), 32'(i * 3 + 100));
        end
        load_entry(5'd31, 32'hDEAD_BEEF);
        start_run(1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_wb(1'b1, m_trace[i][DATA_W+REG_W-1:DATA_W], m_trace[i][DATA_W-1:0]);
        end
        idle_until_done();
        check_done_outputs("full_trace_kept");
        clear_trace();
        start_run(1'b0);
        check_done_outputs("empty_trace");
        start_run(1'b1);
        check_done_outputs("start_beats_load");
    endtask

    task automatic test_back_to_back();
        clear_trace();
        load_entry(5'd1, 32'd5);
        load_entry(5'd2, 32'd7);
        start_run(1'b0);
        drive_wb(1'b1, 5'd1, 32'd5);
        drive_wb(1'b1, 5'd2, 32'd7);
        check_done_outputs("b2b_first");
        start_run(1'b0);
        drive_wb(1'b1, 5'd1, 32'd5);
        drive_wb(1'b1, 5'd2, 32'd7);
        check_done_outputs("b2b_second");
    endtask

    task automatic test_reset_mid_run();
        start_run(1'b0);
        drive_wb(1'b1, 5'd1, 32'd6);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async_reset_mid_run");
        @(negedge clock);
        reset = 1'b1;
        m_count = 0;
        @(negedge clock);
        start_run(1'b0);
        check_done_outputs("after_reset_empty");
        load_entry(5'd1, 32'd5);
        load_entry(5'd2, 32'd7);
        start_run(1'b0);
        drive_wb(1'b1, 5'd1, 32'd5);
        drive_wb(1'b1, 5'd2, 32'd7);
        check_done_outputs("restart_clean");
    endtask

    // Scenario sequence and final report.
    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_timeout();
        test_full_and_empty();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
